// File: rtl/int_log_seq.sv
// Sequential integer logarithm: finds the largest e with a^e <= x by
// multiplying an accumulator by the base once per clock.
module int_log_seq #(
  parameter int BASE_W = 10,
  parameter int VAL_W  = 12,
  parameter int EXP_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BASE_W-1:0] a,
  input  logic [VAL_W-1:0]  x,
  output logic              busy,
  output logic              done,
  output logic [EXP_W-1:0]  result,
  output logic              exact,
  output logic              err
);

  localparam int PW = VAL_W + BASE_W;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state;
  logic [BASE_W-1:0] a_q;
  logic [VAL_W-1:0]  x_q;
  logic [VAL_W-1:0]  acc;
  logic [EXP_W-1:0]  cnt;
  logic [PW-1:0]     p;

  // Full-width product so the overshoot past x_q is never lost to truncation
  assign p    = PW'(acc) * PW'(a_q);
  assign busy = (state == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      done   <= 1'b0;
      result <= '0;
      exact  <= 1'b0;
      err    <= 1'b0;
      a_q    <= '0;
      x_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (a < BASE_W'(2) || x == '0) begin
              done   <= 1'b1;
              err    <= 1'b1;
              result <= '0;
              exact  <= 1'b0;
            end else begin
              a_q   <= a;
              x_q   <= x;
              acc   <= VAL_W'(1);
              cnt   <= '0;
              err   <= 1'b0;
              exact <= 1'b0;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // acc holds a^cnt <= x_q; stop once the next power overshoots
          if (p > PW'(x_q)) begin
            result <= cnt;
            exact  <= (acc == x_q);
            done   <= 1'b1;
            state  <= S_IDLE;
          end else begin
            acc <= p[VAL_W-1:0];
            cnt <= cnt + EXP_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_log_seq.sv
// Directed self-checking bench for int_log_seq: hand-computed logarithms,
// error cases, and start/reset protocol corners.
module tb_int_log_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  a;
  logic [11:0] x;
  logic        busy;
  logic        done;
  logic [9:0]  result;
  logic        exact;
  logic        err;

  int compared;
  int mismatched;
  int cycles;
  int busyCycles;
  logic doneSeen;

  int_log_seq #(.BASE_W(10), .VAL_W(12), .EXP_W(10)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a(a),
    .x(x),
    .busy(busy),
    .done(done),
    .result(result),
    .exact(exact),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive a start pulse; returns #1 after the accepting edge T0
  task automatic applyStimulus(input logic [9:0] av, input logic [11:0] xv);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    x     = xv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the current sample until done is seen (bounded)
  task automatic waitDone(output int k, output int bc);
    k  = 0;
    bc = busy ? 1 : 0;
    while (!done && k < 40) begin
      @(posedge clk);
      #1;
      k++;
      if (busy) bc++;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL timeout: observed no done expected done within 40 cycles");
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n = 1'b1;
    start = 1'b0;
    a     = '0;
    x     = '0;

    // Asynchronous reset before any clock edge
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy",   32'(busy),   32'd0);
    checkOutput("rst_done",   32'(done),   32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_exact",  32'(exact),  32'd0);
    checkOutput("rst_err",    32'(err),    32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // 3^4 = 81 exactly
    applyStimulus(10'd3, 12'd81);
    checkOutput("p81_busy_start", 32'(busy), 32'd1);
    waitDone(cycles, busyCycles);
    checkOutput("p81_latency", 32'(cycles),     32'd5);
    checkOutput("p81_busycyc", 32'(busyCycles), 32'd5);
    checkOutput("p81_result",  32'(result),     32'd4);
    checkOutput("p81_exact",   32'(exact),      32'd1);
    checkOutput("p81_err",     32'(err),        32'd0);
    @(posedge clk); #1;
    checkOutput("p81_done_pulse", 32'(done),   32'd0);
    checkOutput("p81_hold",       32'(result), 32'd4);

    applyStimulus(10'd2, 12'd1000);
    waitDone(cycles, busyCycles);
    checkOutput("l2_1000_result", 32'(result), 32'd9);
    checkOutput("l2_1000_exact",  32'(exact),  32'd0);
    checkOutput("l2_1000_lat",    32'(cycles), 32'd10);

    applyStimulus(10'd2, 12'd4095);
    waitDone(cycles, busyCycles);
    checkOutput("l2_4095_result", 32'(result), 32'd11);
    checkOutput("l2_4095_exact",  32'(exact),  32'd0);
    checkOutput("l2_4095_lat",    32'(cycles), 32'd12);

    applyStimulus(10'd1023, 12'd4095);
    waitDone(cycles, busyCycles);
    checkOutput("l1023_result", 32'(result), 32'd1);
    checkOutput("l1023_exact",  32'(exact),  32'd0);
    checkOutput("l1023_lat",    32'(cycles), 32'd2);

    // x < a, then start coincident with that done pulse
    applyStimulus(10'd5, 12'd4);
    waitDone(cycles, busyCycles);
    checkOutput("l5_4_result", 32'(result), 32'd0);
    checkOutput("l5_4_exact",  32'(exact),  32'd0);
    checkOutput("l5_4_lat",    32'(cycles), 32'd1);
    start = 1'b1;
    a     = 10'd3;
    x     = 12'd81;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("coinc_busy", 32'(busy), 32'd1);
    waitDone(cycles, busyCycles);
    checkOutput("coinc_result", 32'(result), 32'd4);
    checkOutput("coinc_exact",  32'(exact),  32'd1);
    checkOutput("coinc_lat",    32'(cycles), 32'd5);

    applyStimulus(10'd7, 12'd1);
    waitDone(cycles, busyCycles);
    checkOutput("l7_1_result", 32'(result), 32'd0);
    checkOutput("l7_1_exact",  32'(exact),  32'd1);

    // Undefined operations
    applyStimulus(10'd1, 12'd50);
    checkOutput("err_a1_done",   32'(done),   32'd1);
    checkOutput("err_a1_err",    32'(err),    32'd1);
    checkOutput("err_a1_result", 32'(result), 32'd0);
    checkOutput("err_a1_exact",  32'(exact),  32'd0);
    checkOutput("err_a1_busy",   32'(busy),   32'd0);
    @(posedge clk); #1;
    checkOutput("err_a1_pulse", 32'(done), 32'd0);
    checkOutput("err_a1_hold",  32'(err),  32'd1);

    applyStimulus(10'd10, 12'd0);
    checkOutput("err_x0_done", 32'(done), 32'd1);
    checkOutput("err_x0_err",  32'(err),  32'd1);

    // Start while busy must be ignored
    applyStimulus(10'd2, 12'd1000);
    checkOutput("ign_err_cleared", 32'(err), 32'd0);
    @(negedge clk);
    start = 1'b1;
    a     = 10'd3;
    x     = 12'd9;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(cycles, busyCycles);
    checkOutput("ign_result", 32'(result), 32'd9);
    checkOutput("ign_exact",  32'(exact),  32'd0);
    checkOutput("ign_lat",    32'(cycles), 32'd9);

    // Reset in the middle of a run aborts with no done pulse
    applyStimulus(10'd3, 12'd81);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy",   32'(busy),   32'd0);
    checkOutput("mid_rst_done",   32'(done),   32'd0);
    checkOutput("mid_rst_result", 32'(result), 32'd0);
    checkOutput("mid_rst_exact",  32'(exact),  32'd0);
    checkOutput("mid_rst_err",    32'(err),    32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    doneSeen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done || busy) doneSeen = 1'b1;
    end
    checkOutput("mid_rst_no_done", 32'(doneSeen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
